// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the multi-channel input conditioner.
package input_conditioner_pkg;

    localparam int GLITCH_W = 16;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioner channel: synchroniser, stable-count glitch filter and
// registered rise/fall pulses. o_glitch flags a rejected glitch this edge.
module input_conditioner_ch
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_wire,
    input  logic i_bypass,
    input  logic i_mode_chg,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_glitch
);

    localparam int CNT_W = (clog2(FILTER_LEN) < 1) ? 1 : clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_s;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_level_next;
    logic                   w_glitch;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A mode-change edge only clears the count; the level holds until the new mode acts.
    always_comb begin
        w_cnt_next   = '0;
        w_level_next = r_level;
        w_glitch     = 1'b0;
        if (i_bypass) begin
            w_level_next = w_s;
        end else if (!i_mode_chg) begin
            if (w_s == r_level) begin
                w_glitch = (r_cnt != '0);
            end else if (r_cnt == CNT_LAST) begin
                w_level_next = w_s;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_wire};
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_rise  <= w_level_next & ~r_level;
            r_fall  <= ~w_level_next & r_level;
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_glitch = w_glitch;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner top: per-channel filters plus a shared
// saturating glitch counter and BYPASS change detection.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 5
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [WIDTH-1:0]    WIRE_IN,
    input  logic                BYPASS,
    input  logic                CLR_GLITCH,
    output logic [WIDTH-1:0]    WIRE_OUT,
    output logic [WIDTH-1:0]    RISE,
    output logic [WIDTH-1:0]    FALL,
    output logic [GLITCH_W-1:0] GLITCH_CNT
);

    logic                r_bypass_q;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    logic                w_mode_chg;
    logic [WIDTH-1:0]    w_glitch;
    logic [GLITCH_W:0]   w_events;
    logic [GLITCH_W:0]   w_sum;

    assign w_mode_chg = BYPASS ^ r_bypass_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        input_conditioner_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_ch (
            .i_clk     (CLK),
            .i_rst_n   (RESET_N),
            .i_wire    (WIRE_IN[gi]),
            .i_bypass  (BYPASS),
            .i_mode_chg(w_mode_chg),
            .o_level   (WIRE_OUT[gi]),
            .o_rise    (RISE[gi]),
            .o_fall    (FALL[gi]),
            .o_glitch  (w_glitch[gi])
        );
    end

    // One extra bit on the sum exposes overflow for saturation.
    always_comb begin
        w_events = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_events = w_events + (GLITCH_W + 1)'(w_glitch[i]);
        end
        w_sum = {1'b0, r_glitch_cnt} + w_events;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bypass_q   <= 1'b0;
            r_glitch_cnt <= '0;
        end else begin
            r_bypass_q <= BYPASS;
            if (CLR_GLITCH) begin
                r_glitch_cnt <= '0;
            end else if (w_sum[GLITCH_W]) begin
                r_glitch_cnt <= '1;
            end else begin
                r_glitch_cnt <= w_sum[GLITCH_W-1:0];
            end
        end
    end

    assign GLITCH_CNT = r_glitch_cnt;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a behavioural model predicts every
// cycle's outputs into a queue, and a monitor compares on the falling edge.
module tb_input_conditioner;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 5;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic [WIDTH-1:0]  WIRE_IN;
    logic              BYPASS;
    logic              CLR_GLITCH;
    logic [WIDTH-1:0]  WIRE_OUT;
    logic [WIDTH-1:0]  RISE;
    logic [WIDTH-1:0]  FALL;
    logic [15:0]       GLITCH_CNT;

    typedef struct packed {
        logic [WIDTH-1:0] wout;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic [15:0]      gcnt;
    } exp_t;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    // Reference model state: history of raw samples, persistence run lengths, levels.
    logic [WIDTH-1:0] mSync[$];
    int               mRun[WIDTH];
    logic [WIDTH-1:0] mLevel;
    int               mGlitch;
    logic             mPrevBypass;

    input_conditioner #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .WIRE_IN   (WIRE_IN),
        .BYPASS    (BYPASS),
        .CLR_GLITCH(CLR_GLITCH),
        .WIRE_OUT  (WIRE_OUT),
        .RISE      (RISE),
        .FALL      (FALL),
        .GLITCH_CNT(GLITCH_CNT)
    );

    always #5 CLK = ~CLK;

    task modelReset();
        mSync.delete();
        for (int i = 0; i < SYNC_STAGES; i++) mSync.push_back('0);
        for (int i = 0; i < WIDTH; i++) mRun[i] = 0;
        mLevel      = '0;
        mGlitch     = 0;
        mPrevBypass = 1'b0;
    endtask

    task modelStep();
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] newLevel;
        int               events;
        exp_t             e;
        s        = mSync[0];
        newLevel = mLevel;
        events   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (BYPASS) begin
                newLevel[i] = s[i];
                mRun[i]     = 0;
            end else if (BYPASS != mPrevBypass) begin
                mRun[i] = 0;
            end else if (s[i] == mLevel[i]) begin
                if (mRun[i] > 0) events++;
                mRun[i] = 0;
            end else if (mRun[i] + 1 >= FILTER_LEN) begin
                newLevel[i] = s[i];
                mRun[i]     = 0;
            end else begin
                mRun[i]++;
            end
        end
        if (CLR_GLITCH) mGlitch = 0;
        else            mGlitch = (mGlitch + events > 65535) ? 65535 : mGlitch + events;
        e.wout = newLevel;
        e.rise = newLevel & ~mLevel;
        e.fall = ~newLevel & mLevel;
        e.gcnt = 16'(mGlitch);
        expQ.push_back(e);
        mLevel      = newLevel;
        mPrevBypass = BYPASS;
        mSync.push_back(WIRE_IN);
        void'(mSync.pop_front());
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            modelReset();
            expQ.delete();
            expQ.push_back('0);
        end else begin
            modelStep();
        end
    end

    task checkOutput(input string name, input exp_t e);
        exp_t act;
        act = {WIRE_OUT, RISE, FALL, GLITCH_CNT};
        nCompared++;
        if (act !== e) begin
            nMismatched++;
            $display("[TB] FAIL %s t=%0t: got out=%h rise=%h fall=%h gcnt=%h, want out=%h rise=%h fall=%h gcnt=%h",
                     name, $time, act.wout, act.rise, act.fall, act.gcnt,
                     e.wout, e.rise, e.fall, e.gcnt);
        end
    endtask

    task checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s t=%0t: got %h, want %h", name, $time, actual, expected);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cycle", e);
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] w, input logic b, input logic c, input int n);
        WIRE_IN    = w;
        BYPASS     = b;
        CLR_GLITCH = c;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] w;
        logic             byp;
        logic             clr;

        RESET_N    = 1'b0;
        WIRE_IN    = '1;
        BYPASS     = 1'b0;
        CLR_GLITCH = 1'b0;

        $display("[TB] reset and idle release");
        applyStimulus(4'hF, 1'b0, 1'b0, 3);
        checkValue("reset_idle", {4'b0, WIRE_OUT, RISE, FALL, GLITCH_CNT}, 32'h0);
        RESET_N = 1'b1;
        applyStimulus(4'hF, 1'b0, 1'b0, 10);
        applyStimulus(4'h0, 1'b0, 1'b0, 10);

        $display("[TB] single-channel glitch and accepted pulse");
        applyStimulus(4'h1, 1'b0, 1'b0, 3);
        applyStimulus(4'h0, 1'b0, 1'b0, 10);
        applyStimulus(4'h1, 1'b0, 1'b0, 5);
        applyStimulus(4'h0, 1'b0, 1'b0, 12);

        $display("[TB] simultaneous glitches, then cleared on counting edge");
        applyStimulus(4'hF, 1'b0, 1'b0, 2);
        applyStimulus(4'h0, 1'b0, 1'b0, 8);
        applyStimulus(4'hF, 1'b0, 1'b0, 2);
        applyStimulus(4'h0, 1'b0, 1'b0, 2);
        applyStimulus(4'h0, 1'b0, 1'b1, 1);
        applyStimulus(4'h0, 1'b0, 1'b0, 8);

        $display("[TB] bypass pulse and mode toggle mid-count");
        applyStimulus(4'h0, 1'b1, 1'b0, 4);
        applyStimulus(4'h4, 1'b1, 1'b0, 1);
        applyStimulus(4'h0, 1'b1, 1'b0, 6);
        applyStimulus(4'h0, 1'b0, 1'b0, 6);
        applyStimulus(4'h2, 1'b0, 1'b0, 4);
        applyStimulus(4'h2, 1'b1, 1'b0, 1);
        applyStimulus(4'h2, 1'b0, 1'b0, 8);
        applyStimulus(4'h0, 1'b0, 1'b0, 3);
        applyStimulus(4'h0, 1'b1, 1'b0, 1);
        applyStimulus(4'h0, 1'b0, 1'b0, 10);

        $display("[TB] asynchronous reset during accumulation");
        applyStimulus(4'hF, 1'b0, 1'b0, 4);
        @(negedge CLK);
        #1;
        RESET_N = 1'b0;
        WIRE_IN = 4'h0;
        #1;
        checkValue("async_reset", {4'b0, WIRE_OUT, RISE, FALL, GLITCH_CNT}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        applyStimulus(4'h0, 1'b0, 1'b0, 10);

        $display("[TB] glitch counter saturation");
        for (int n = 0; n < 17600; n++) begin
            applyStimulus(4'hF, 1'b0, 1'b0, 1);
            applyStimulus(4'h0, 1'b0, 1'b0, 1);
        end
        applyStimulus(4'h0, 1'b0, 1'b0, 4);
        @(negedge CLK);
        #1;
        checkValue("saturation", {16'h0, GLITCH_CNT}, 32'h0000FFFF);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            w = WIRE_IN;
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(3) == 0) w[i] = ~w[i];
            end
            byp = ($urandom_range(31) == 0) ? ~BYPASS : BYPASS;
            clr = ($urandom_range(39) == 0);
            applyStimulus(w, byp, clr, 1);
        end
        applyStimulus(4'h0, 1'b0, 1'b0, 12);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
